// File: rtl/xadc_aux_filter.sv
// Decimating box-car averager for the two XADC aux channels, producing 12-bit
// window averages with a one-cycle valid strobe and hysteretic over-threshold flags.
module xadc_aux_filter #(
    parameter int          SAMPLE_DIV = 10000,
    parameter int          LOG2_AVG   = 4,
    parameter logic [11:0] THRESH_HI  = 12'hC00,
    parameter logic [11:0] THRESH_LO  = 12'hA00
) (
    input  logic        DCLK,
    input  logic        RESET_N,
    input  logic        EN,
    input  logic [15:0] MEASURED_AUX_A,
    input  logic [15:0] MEASURED_AUX_B,
    output logic [11:0] AVG_A,
    output logic [11:0] AVG_B,
    output logic        AVG_VALID,
    output logic        OVER_A,
    output logic        OVER_B
);

    localparam int                  CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int                  ACC_W     = 12 + LOG2_AVG;
    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [LOG2_AVG-1:0] N_LAST    = {LOG2_AVG{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [LOG2_AVG-1:0] n_q, n_d;
    logic                avg_valid_q, avg_valid_d;
    logic                tick;
    logic                capture_en;
    logic                accum_en;
    logic                done_en;
    logic [23:0]         code_all;
    logic [23:0]         avg_all;
    logic [1:0]          over_all;
    logic                unused_low_nibbles;

    // The XADC code is MSB-justified; the low nibble carries no information.
    assign code_all           = {MEASURED_AUX_B[15:4], MEASURED_AUX_A[15:4]};
    assign unused_low_nibbles = ^{MEASURED_AUX_A[3:0], MEASURED_AUX_B[3:0]};

    assign capture_en = EN && (state_q == ST_CAPTURE);
    assign accum_en   = EN && (state_q == ST_ACCUM);
    assign done_en    = EN && (state_q == ST_DONE);

    always_comb begin
        tick        = EN && (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick_cnt_q + 1'b1;
        state_d     = state_q;
        n_d         = n_q;
        avg_valid_d = 1'b0;
        if (!EN || tick) begin
            tick_cnt_d = '0;
        end
        // Dropping EN abandons the partial window from any state.
        if (!EN) begin
            state_d = ST_IDLE;
            n_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    n_d     = n_q + 1'b1;
                    state_d = (n_q == N_LAST) ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    n_d         = '0;
                    avg_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            n_q         <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            n_q         <= n_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [11:0]      raw_q, raw_d;
            logic [11:0]      smp_q, smp_d;
            logic [11:0]      avg_q, avg_d;
            logic [11:0]      avg_new;
            logic [ACC_W-1:0] acc_q, acc_d;
            logic             over_q, over_d;

            always_comb begin
                raw_d   = code_all[gi*12 +: 12];
                smp_d   = capture_en ? raw_q : smp_q;
                // Upper 12 bits of the accumulator are the truncated window mean.
                avg_new = acc_q[ACC_W-1 -: 12];
                acc_d   = acc_q;
                avg_d   = avg_q;
                over_d  = over_q;
                if (!EN) begin
                    acc_d = '0;
                end else if (accum_en) begin
                    acc_d = acc_q + ACC_W'(smp_q);
                end else if (done_en) begin
                    acc_d = '0;
                    avg_d = avg_new;
                    if (avg_new >= THRESH_HI) begin
                        over_d = 1'b1;
                    end else if (avg_new <= THRESH_LO) begin
                        over_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge DCLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    raw_q  <= '0;
                    smp_q  <= '0;
                    avg_q  <= '0;
                    acc_q  <= '0;
                    over_q <= 1'b0;
                end else begin
                    raw_q  <= raw_d;
                    smp_q  <= smp_d;
                    avg_q  <= avg_d;
                    acc_q  <= acc_d;
                    over_q <= over_d;
                end
            end

            assign avg_all[gi*12 +: 12] = avg_q;
            assign over_all[gi]         = over_q;
        end
    endgenerate

    assign AVG_A     = avg_all[11:0];
    assign AVG_B     = avg_all[23:12];
    assign OVER_A    = over_all[0];
    assign OVER_B    = over_all[1];
    assign AVG_VALID = avg_valid_q;

endmodule

// File: tb/tb_xadc_aux_filter.sv
// Directed bench for xadc_aux_filter with SAMPLE_DIV=8, LOG2_AVG=4 (128-cycle windows).
module tb_xadc_aux_filter;

    localparam int DIV = 8;
    // EN raised before edge 1: 16th tick in cycle 16*DIV-1, strobe visible at +4.
    localparam int FIRST_EDGES = 16 * DIV + 3;
    localparam int PERIOD      = 16 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] aux_a = 16'h0000;
    logic [15:0] aux_b = 16'h0000;
    logic [11:0] avg_a, avg_b;
    logic        avg_valid, over_a, over_b;

    int checks = 0;
    int errors = 0;

    xadc_aux_filter #(
        .SAMPLE_DIV(DIV),
        .LOG2_AVG  (4),
        .THRESH_HI (12'hC00),
        .THRESH_LO (12'hA00)
    ) dut (
        .DCLK          (clk),
        .RESET_N       (rst_n),
        .EN            (en),
        .MEASURED_AUX_A(aux_a),
        .MEASURED_AUX_B(aux_b),
        .AVG_A         (avg_a),
        .AVG_B         (avg_b),
        .AVG_VALID     (avg_valid),
        .OVER_A        (over_a),
        .OVER_B        (over_b)
    );

    always #5 clk = ~clk;

    // Returns number of rising edges until AVG_VALID is seen, or -1 on timeout.
    task automatic wait_valid(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (avg_valid === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    // Restart from a clean window; returns at the negedge where EN rises.
    task automatic start_run(input logic [15:0] a, input logic [15:0] b);
        en = 1'b0;
        repeat (2) @(negedge clk);
        aux_a = a;
        aux_b = b;
        en    = 1'b1;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({avg_a, avg_b, avg_valid, over_a, over_b} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h v=%b oa=%b ob=%b expected all 0",
                     avg_a, avg_b, avg_valid, over_a, over_b);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0 || avg_a !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle: got v=%b a=%h expected v=0 a=000", avg_valid, avg_a);
        end
        $display("reset: a=%h b=%h v=%b oa=%b ob=%b", avg_a, avg_b, avg_valid, over_a, over_b);
    endtask

    task automatic test_constant;
        int e;
        start_run(16'hFFF0, 16'h0010);
        wait_valid(400, e);
        $display("const window: edges=%0d a=%h b=%h oa=%b ob=%b", e, avg_a, avg_b, over_a, over_b);
        checks++;
        if (e !== FIRST_EDGES) begin
            errors++;
            $display("FAIL const_latency: got %0d edges expected %0d", e, FIRST_EDGES);
        end
        checks++;
        if (avg_a !== 12'hFFF || avg_b !== 12'h001) begin
            errors++;
            $display("FAIL const_avg: got a=%h b=%h expected a=fff b=001", avg_a, avg_b);
        end
        checks++;
        if (over_a !== 1'b1 || over_b !== 1'b0) begin
            errors++;
            $display("FAIL const_over: got oa=%b ob=%b expected oa=1 ob=0", over_a, over_b);
        end
        @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL const_pulse_width: got v=%b expected 0", avg_valid);
        end
        wait_valid(400, e);
        $display("const window: edges=%0d a=%h b=%h", e, avg_a, avg_b);
        checks++;
        if (e !== PERIOD - 1) begin
            errors++;
            $display("FAIL const_period: got %0d edges expected %0d", e, PERIOD - 1);
        end
    endtask

    task automatic test_ramp;
        int e;
        start_run(16'h0000, 16'h8000);
        for (int k = 0; k < 16; k++) begin
            aux_a = {12'(16 * k), 4'h0};
            repeat (DIV) @(negedge clk);
        end
        wait_valid(20, e);
        $display("ramp window: edges=%0d a=%h b=%h oa=%b ob=%b", e, avg_a, avg_b, over_a, over_b);
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL ramp_latency: got %0d edges expected 3", e);
        end
        checks++;
        if (avg_a !== 12'h078) begin
            errors++;
            $display("FAIL ramp_avg_a: got %h expected 078", avg_a);
        end
        checks++;
        if (avg_b !== 12'h800) begin
            errors++;
            $display("FAIL ramp_avg_b: got %h expected 800", avg_b);
        end
        checks++;
        if (over_a !== 1'b0 || over_b !== 1'b0) begin
            errors++;
            $display("FAIL ramp_over: got oa=%b ob=%b expected 0 0", over_a, over_b);
        end
    endtask

    task automatic test_hysteresis;
        logic [11:0] vals [5];
        logic        exp_over [5];
        int          e;
        vals[0] = 12'hC00; exp_over[0] = 1'b1;
        vals[1] = 12'hB00; exp_over[1] = 1'b1;
        vals[2] = 12'hA00; exp_over[2] = 1'b0;
        vals[3] = 12'hBFF; exp_over[3] = 1'b0;
        vals[4] = 12'hC00; exp_over[4] = 1'b1;
        start_run({vals[0], 4'h0}, 16'h8000);
        for (int w = 0; w < 5; w++) begin
            aux_a = {vals[w], 4'h0};
            wait_valid(400, e);
            $display("hyst window %0d: edges=%0d a=%h oa=%b", w, e, avg_a, over_a);
            checks++;
            if (e !== ((w == 0) ? FIRST_EDGES : PERIOD)) begin
                errors++;
                $display("FAIL hyst_timing[%0d]: got %0d edges expected %0d", w, e,
                         (w == 0) ? FIRST_EDGES : PERIOD);
            end
            checks++;
            if (avg_a !== vals[w]) begin
                errors++;
                $display("FAIL hyst_avg[%0d]: got %h expected %h", w, avg_a, vals[w]);
            end
            checks++;
            if (over_a !== exp_over[w]) begin
                errors++;
                $display("FAIL hyst_over[%0d]: got %b expected %b", w, over_a, exp_over[w]);
            end
        end
    endtask

    task automatic test_en_low;
        int e;
        bit hold_bad;
        start_run(16'h5000, 16'h8000);
        repeat (44) @(negedge clk);
        en       = 1'b0;
        hold_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (avg_valid !== 1'b0 || avg_a !== 12'hC00 || over_a !== 1'b1) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL en_low_hold: got v=%b a=%h oa=%b expected v=0 a=c00 oa=1",
                     avg_valid, avg_a, over_a);
        end
        aux_a = 16'h1000;
        en    = 1'b1;
        wait_valid(400, e);
        $display("en_low window: edges=%0d a=%h oa=%b", e, avg_a, over_a);
        checks++;
        if (e !== FIRST_EDGES) begin
            errors++;
            $display("FAIL en_low_latency: got %0d edges expected %0d", e, FIRST_EDGES);
        end
        checks++;
        if (avg_a !== 12'h100 || over_a !== 1'b0) begin
            errors++;
            $display("FAIL en_low_avg: got a=%h oa=%b expected a=100 oa=0", avg_a, over_a);
        end
    endtask

    task automatic test_async_reset;
        int e;
        start_run(16'hFFF0, 16'h8000);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-window: a=%h b=%h v=%b oa=%b ob=%b", avg_a, avg_b, avg_valid, over_a, over_b);
        checks++;
        if (avg_a !== 12'h000 || avg_b !== 12'h000 || avg_valid !== 1'b0 ||
            over_a !== 1'b0 || over_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_window: got a=%h b=%h v=%b expected all 0", avg_a, avg_b, avg_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(400, e);
        $display("after reset window: edges=%0d a=%h b=%h oa=%b", e, avg_a, avg_b, over_a);
        checks++;
        if (e !== FIRST_EDGES) begin
            errors++;
            $display("FAIL reset_restart_latency: got %0d edges expected %0d", e, FIRST_EDGES);
        end
        checks++;
        if (avg_a !== 12'hFFF || avg_b !== 12'h800 || over_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart_avg: got a=%h b=%h oa=%b expected fff 800 1", avg_a, avg_b, over_a);
        end
        // Advance to the DONE cycle of the following window.
        repeat (PERIOD - 1) @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_done_valid: got %b expected 0", avg_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        $display("reset in done: a=%h b=%h v=%b oa=%b", avg_a, avg_b, avg_valid, over_a);
        checks++;
        if (avg_a !== 12'h000 || avg_b !== 12'h000 || over_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_done: got a=%h b=%h oa=%b expected all 0", avg_a, avg_b, over_a);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0 || avg_a !== 12'h000) begin
            errors++;
            $display("FAIL done_suppressed: got v=%b a=%h expected v=0 a=000", avg_valid, avg_a);
        end
    endtask

    task automatic test_low_nibble;
        int e;
        start_run(16'h000F, 16'h001F);
        wait_valid(400, e);
        $display("low nibble window: edges=%0d a=%h b=%h oa=%b", e, avg_a, avg_b, over_a);
        checks++;
        if (e !== FIRST_EDGES) begin
            errors++;
            $display("FAIL nibble_latency: got %0d edges expected %0d", e, FIRST_EDGES);
        end
        checks++;
        if (avg_a !== 12'h000 || avg_b !== 12'h001 || over_a !== 1'b0) begin
            errors++;
            $display("FAIL nibble_avg: got a=%h b=%h oa=%b expected 000 001 0", avg_a, avg_b, over_a);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_hysteresis();
        test_en_low();
        test_async_reset();
        test_low_nibble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
